// File: rtl/xor_out_deglitch.sv
// rtl/xor_out_deglitch.sv - synchroniser, pulse-rejecting filter and edge counter for gate-network output z
// Optional rejected-pulse counter (glitch_cnt) enabled by defining XOR_DEGLITCH_GLITCH_CNT_EN.
module xor_out_deglitch #(
  parameter int STABLE_CYCLES = 3,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             clr,
  output logic             dout,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] edge_cnt,
  output logic             cnt_sat
`ifdef XOR_DEGLITCH_GLITCH_CNT_EN
  ,
  output logic [CNT_W-1:0] glitch_cnt
`endif
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam logic [SW-1:0] LAST = SW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {STABLE_LO, PEND_HI, STABLE_HI, PEND_LO} state_e;

  generate
    if (STABLE_CYCLES < 1) begin : g_bad_stable_cycles
      $error("xor_out_deglitch: STABLE_CYCLES must be >= 1");
    end
  endgenerate

  state_e           state_q, state_d;
  logic [SW-1:0]    stab_q, stab_d;
  logic             s1_q, s2_q;
  logic             dout_q, dout_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             glitch_ev;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic             cnt_sat_q, cnt_sat_d;
`ifdef XOR_DEGLITCH_GLITCH_CNT_EN
  logic [CNT_W-1:0] glitch_cnt_q, glitch_cnt_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      state_q    <= STABLE_LO;
      stab_q     <= '0;
      dout_q     <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      edge_cnt_q <= '0;
      cnt_sat_q  <= 1'b0;
`ifdef XOR_DEGLITCH_GLITCH_CNT_EN
      glitch_cnt_q <= '0;
`endif
    end else begin
      s1_q       <= din;
      s2_q       <= s1_q;
      state_q    <= state_d;
      stab_q     <= stab_d;
      dout_q     <= dout_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      edge_cnt_q <= edge_cnt_d;
      cnt_sat_q  <= cnt_sat_d;
`ifdef XOR_DEGLITCH_GLITCH_CNT_EN
      glitch_cnt_q <= glitch_cnt_d;
`endif
    end
  end

  // stab_cnt counts consecutive s2 samples that disagree with dout; LAST+1 samples commit the change
  always_comb begin
    state_d = state_q;
    stab_d  = stab_q;
    case (state_q)
      STABLE_LO:
        if (s2_q) begin
          if (STABLE_CYCLES == 1) begin
            state_d = STABLE_HI;
            stab_d  = '0;
          end else begin
            state_d = PEND_HI;
            stab_d  = SW'(1);
          end
        end
      PEND_HI:
        if (!s2_q) begin
          state_d = STABLE_LO;
          stab_d  = '0;
        end else if (stab_q == LAST) begin
          state_d = STABLE_HI;
          stab_d  = '0;
        end else begin
          stab_d = stab_q + 1'b1;
        end
      STABLE_HI:
        if (!s2_q) begin
          if (STABLE_CYCLES == 1) begin
            state_d = STABLE_LO;
            stab_d  = '0;
          end else begin
            state_d = PEND_LO;
            stab_d  = SW'(1);
          end
        end
      PEND_LO:
        if (s2_q) begin
          state_d = STABLE_HI;
          stab_d  = '0;
        end else if (stab_q == LAST) begin
          state_d = STABLE_LO;
          stab_d  = '0;
        end else begin
          stab_d = stab_q + 1'b1;
        end
      default: begin
        state_d = STABLE_LO;
        stab_d  = '0;
      end
    endcase
  end

  always_comb begin
    dout_d    = (state_d == STABLE_HI) || (state_d == PEND_LO);
    rise_d    = dout_d & ~dout_q;
    fall_d    = ~dout_d & dout_q;
    glitch_ev = ((state_q == PEND_HI) && (state_d == STABLE_LO)) ||
                ((state_q == PEND_LO) && (state_d == STABLE_HI));
  end

  // Counters follow the registered pulses, so clr in a pulse cycle suppresses that increment
  always_comb begin
    edge_cnt_d = edge_cnt_q;
    cnt_sat_d  = cnt_sat_q;
    if (clr) begin
      edge_cnt_d = '0;
      cnt_sat_d  = 1'b0;
    end else begin
      if ((rise_q || fall_q) && !(&edge_cnt_q)) edge_cnt_d = edge_cnt_q + 1'b1;
      cnt_sat_d = cnt_sat_q | (&edge_cnt_d);
    end
  end

`ifdef XOR_DEGLITCH_GLITCH_CNT_EN
  always_comb begin
    glitch_cnt_d = glitch_cnt_q;
    if (clr) glitch_cnt_d = '0;
    else if (glitch_ev && !(&glitch_cnt_q)) glitch_cnt_d = glitch_cnt_q + 1'b1;
  end
  assign glitch_cnt = glitch_cnt_q;
`else
  logic unused_glitch_ev;
  assign unused_glitch_ev = glitch_ev;
`endif

  assign dout     = dout_q;
  assign rise     = rise_q;
  assign fall     = fall_q;
  assign edge_cnt = edge_cnt_q;
  assign cnt_sat  = cnt_sat_q;

endmodule

// File: tb/tb_xor_out_deglitch.sv
// tb/tb_xor_out_deglitch.sv - scoreboard bench for xor_out_deglitch (CNT_W=8 and CNT_W=4 instances)
// Build with XOR_DEGLITCH_GLITCH_CNT_EN defined to also check glitch_cnt.
module tb_xor_out_deglitch;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic din = 1'b0;
  logic clr = 1'b0;

  logic       dout8, rise8, fall8, sat8;
  logic [7:0] cnt8;
  logic       dout4, rise4, fall4, sat4;
  logic [3:0] cnt4;
`ifdef XOR_DEGLITCH_GLITCH_CNT_EN
  logic [7:0] glitch8;
  logic [3:0] glitch4;
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  xor_out_deglitch #(.STABLE_CYCLES(3), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .clr(clr),
    .dout(dout8), .rise(rise8), .fall(fall8), .edge_cnt(cnt8), .cnt_sat(sat8)
`ifdef XOR_DEGLITCH_GLITCH_CNT_EN
    , .glitch_cnt(glitch8)
`endif
  );

  xor_out_deglitch #(.STABLE_CYCLES(3), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .din(din), .clr(clr),
    .dout(dout4), .rise(rise4), .fall(fall4), .edge_cnt(cnt4), .cnt_sat(sat4)
`ifdef XOR_DEGLITCH_GLITCH_CNT_EN
    , .glitch_cnt(glitch4)
`endif
  );

  typedef struct {
    bit is_rise;
    int cyc;
    int cnt8;
    bit sat8;
    int cnt4;
    bit sat4;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;
  int m8 = 0, m4 = 0;
  bit ms8 = 0, ms4 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Pulse expected at the negedge following edge k+4, where k is the first edge after this call
  task automatic expect_edge(input bit r, input int c, input bit clr_at);
    exp_t e;
    if (clr_at) begin
      m8 = 0; m4 = 0; ms8 = 0; ms4 = 0;
    end else begin
      if (m8 != 255) m8++;
      if (m8 == 255) ms8 = 1;
      if (m4 != 15) m4++;
      if (m4 == 15) ms4 = 1;
    end
    e = '{r, c, m8, ms8, m4, ms4};
    q.push_back(e);
  endtask

  task automatic toggle_to(input bit v);
    din = v;
    expect_edge(v, cyc + 5, 1'b0);
    wait_n(8);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_dout"}, {dout8, dout4}, 0);
    chk({tag, "_rise"}, {rise8, rise4}, 0);
    chk({tag, "_fall"}, {fall8, fall4}, 0);
    chk({tag, "_cnt8"}, cnt8, 0);
    chk({tag, "_cnt4"}, cnt4, 0);
    chk({tag, "_sat"}, {sat8, sat4}, 0);
`ifdef XOR_DEGLITCH_GLITCH_CNT_EN
    chk({tag, "_glitch"}, {glitch8, glitch4}, 0);
`endif
  endtask

  // Monitor: every rise/fall pulse must match the head of the scoreboard queue
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && (rise8 || fall8 || rise4 || fall4)) begin
        if (q.size() == 0) begin
          chk("unexpected_pulse", 1, 0);
        end else begin
          e = q.pop_front();
          chk("pulse_cycle", cyc, e.cyc);
          chk("rise8", rise8, e.is_rise);
          chk("fall8", fall8, !e.is_rise);
          chk("rise4", rise4, e.is_rise);
          chk("fall4", fall4, !e.is_rise);
          chk("dout8", dout8, e.is_rise);
          chk("dout4", dout4, e.is_rise);
          @(negedge clk);
          chk("pulse_width", {rise8, fall8, rise4, fall4}, 0);
          chk("edge_cnt8", cnt8, e.cnt8);
          chk("cnt_sat8", sat8, e.sat8);
          chk("edge_cnt4", cnt4, e.cnt4);
          chk("cnt_sat4", sat4, e.sat4);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; din = 1'b0; clr = 1'b0;
    wait_n(3);
    rst_n = 1'b1;

    // Reset state with din low
    wait_n(10);
    chk_zero("t1");

    // Clean rise then fall
    toggle_to(1'b1);
    toggle_to(1'b0);

    // 2-cycle and 1-cycle pulses are rejected
    din = 1'b1; wait_n(2); din = 1'b0; wait_n(10);
    chk("t3_dout", {dout8, dout4}, 0);
    chk("t3_cnt8", cnt8, 2);
    din = 1'b1; wait_n(1); din = 1'b0; wait_n(10);
    chk("t3b_cnt4", cnt4, 2);
`ifdef XOR_DEGLITCH_GLITCH_CNT_EN
    chk("t3_glitch8", glitch8, 2);
    chk("t3_glitch4", glitch4, 2);
`endif

    // Async reset in PEND_HI, then rise 5 edges after release
    din = 1'b1; wait_n(3);
    #2 rst_n = 1'b0;
    #1 chk_zero("t5_rst");
    m8 = 0; m4 = 0; ms8 = 0; ms4 = 0;
    @(negedge clk);
    rst_n = 1'b1;
    expect_edge(1'b1, cyc + 5, 1'b0);
    wait_n(8);

    // 16 more edges saturate the 4-bit counter; clr clears counters only
    for (int i = 0; i < 16; i++) toggle_to(i[0]);
    chk("t4_cnt4", cnt4, 15);
    chk("t4_sat4", sat4, 1);
    chk("t4_cnt8", cnt8, 17);
    chk("t4_sat8", sat8, 0);
    clr = 1'b1; wait_n(1); clr = 1'b0;
    m8 = 0; m4 = 0; ms8 = 0; ms4 = 0;
    chk("t4_clr_cnt", {cnt8, cnt4}, 0);
    chk("t4_clr_sat", {sat8, sat4}, 0);
    chk("t4_dout_kept", {dout8, dout4}, 2'b11);

    // clr in the rise cycle wins over the increment
    toggle_to(1'b0); toggle_to(1'b1); toggle_to(1'b0); toggle_to(1'b1); toggle_to(1'b0);
    din = 1'b1;
    expect_edge(1'b1, cyc + 5, 1'b1);
    wait_n(5);
    chk("t6_rise_now", rise8, 1);
    chk("t6_cnt_before", cnt8, 5);
    clr = 1'b1; wait_n(1); clr = 1'b0;
    wait_n(1);
    chk("t6_cnt_after", cnt8, 0);
    chk("t6_dout", dout8, 1);
    wait_n(10);

    chk("pending_expected", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
